// File: rtl/prescaled_updown_counter_if.sv
// prescaled_updown_counter_if
// Groups the control/status bundle of prescaled_updown_counter. The counter
// attaches through the slave modport; whoever drives the controls uses master.
// Optional capture signals exist only when PRESCALED_COUNTER_CAPTURE_EN is defined.
`timescale 1ns/1ps

interface prescaled_updown_counter_if #(
    parameter int P_COUNT_W    = 16,
    parameter int P_PRESCALE_W = 8
);
    logic                    i_enable;
    logic                    i_dir;
    logic                    i_sat;
    logic                    i_load;
    logic [P_COUNT_W-1:0]    i_load_val;
    logic [P_PRESCALE_W-1:0] i_prescale;
    logic [P_COUNT_W-1:0]    i_cmp_val;
    logic [P_COUNT_W-1:0]    o_count;
    logic                    o_tick;
    logic                    o_tc;
    logic                    o_match;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    logic                    i_capture;
    logic [P_COUNT_W-1:0]    o_capture;
    logic                    o_capture_vld;

    modport master (
        output i_enable, i_dir, i_sat, i_load, i_load_val, i_prescale, i_cmp_val, i_capture,
        input  o_count, o_tick, o_tc, o_match, o_capture, o_capture_vld
    );
    modport slave (
        input  i_enable, i_dir, i_sat, i_load, i_load_val, i_prescale, i_cmp_val, i_capture,
        output o_count, o_tick, o_tc, o_match, o_capture, o_capture_vld
    );
`else
    modport master (
        output i_enable, i_dir, i_sat, i_load, i_load_val, i_prescale, i_cmp_val,
        input  o_count, o_tick, o_tc, o_match
    );
    modport slave (
        input  i_enable, i_dir, i_sat, i_load, i_load_val, i_prescale, i_cmp_val,
        output o_count, o_tick, o_tc, o_match
    );
`endif
endinterface

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter
// Up/down counter over 0..P_MAX with runtime prescaler, synchronous load with
// clamp, saturate-or-wrap boundary handling, tick/terminal-count pulses and a
// registered compare match. Optional snapshot capture is built when the macro
// PRESCALED_COUNTER_CAPTURE_EN is defined. Interface parameters must match.
`timescale 1ns/1ps

module prescaled_updown_counter #(
    parameter int P_COUNT_W    = 16,
    parameter int P_MAX        = 65535,
    parameter int P_PRESCALE_W = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    prescaled_updown_counter_if.slave     bus
);
    localparam logic [P_COUNT_W-1:0] L_MAX = P_COUNT_W'(P_MAX);
    localparam logic [P_COUNT_W-1:0] L_ONE = P_COUNT_W'(1);

    logic [P_COUNT_W-1:0]    count_q, count_d;
    logic [P_PRESCALE_W-1:0] psc_q, psc_d;
    logic                    tick_q, tick_d;
    logic                    tc_q, tc_d;
    logic                    match_q;
    logic                    step;

    // Next-state: load beats step beats hold; step comes from the prescaler.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        psc_d   = psc_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        step    = 1'b0;

        if (bus.i_load) begin
            count_d = (bus.i_load_val > L_MAX) ? L_MAX : bus.i_load_val;
            psc_d   = '0;
        end else if (bus.i_enable) begin
            // ">=" lets a freshly reduced divisor fire at once instead of locking out.
            if (psc_q >= bus.i_prescale) begin
                step  = 1'b1;
                psc_d = '0;
            end else begin
                psc_d = psc_q + P_PRESCALE_W'(1);
            end
        end

        if (step) begin
            tick_d = 1'b1;
            if (bus.i_dir) begin
                if (count_q == L_MAX) begin
                    if (!bus.i_sat) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end
                end else begin
                    count_d = count_q + L_ONE;
                    tc_d    = bus.i_sat && (count_q == L_MAX - L_ONE);
                end
            end else begin
                if (count_q == '0) begin
                    if (!bus.i_sat) begin
                        count_d = L_MAX;
                        tc_d    = 1'b1;
                    end
                end else begin
                    count_d = count_q - L_ONE;
                    tc_d    = bus.i_sat && (count_q == L_ONE);
                end
            end
        end
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            psc_q   <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            count_q <= count_d;
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
            match_q <= (count_d == bus.i_cmp_val);
        end
    end

    assign bus.o_count = count_q;
    assign bus.o_tick  = tick_q;
    assign bus.o_tc    = tc_q;
    assign bus.o_match = match_q;

`ifdef PRESCALED_COUNTER_CAPTURE_EN
    logic [P_COUNT_W-1:0] capture_q;
    logic                 capture_vld_q;

    // Snapshot of the pre-update count, independent of load and enable.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            capture_q     <= '0;
            capture_vld_q <= 1'b0;
        end else begin
            capture_vld_q <= bus.i_capture;
            if (bus.i_capture) begin
                capture_q <= count_q;
            end
        end
    end

    assign bus.o_capture     = capture_q;
    assign bus.o_capture_vld = capture_vld_q;
`endif

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb_prescaled_updown_counter
// Scoreboard bench: the driver applies one cycle of stimulus, computes the
// expected registered outputs with an arithmetic reference model and queues
// them; a monitor pops one entry per clock edge and compares.
`timescale 1ns/1ps

module tb_prescaled_updown_counter;
    localparam int CW   = 4;
    localparam int PMAX = 9;
    localparam int PW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prescaled_updown_counter_if #(.P_COUNT_W(CW), .P_PRESCALE_W(PW)) bus ();

    prescaled_updown_counter #(.P_COUNT_W(CW), .P_MAX(PMAX), .P_PRESCALE_W(PW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    typedef struct {
        int count;
        int tick;
        int tc;
        int match;
        int cap;
        int cap_vld;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_count = 0;
    int m_psc   = 0;
    int m_cap   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: apply inputs, predict the edge, queue, advance.
    task automatic drive(input logic en, input logic dir, input logic sat, input logic load,
                         input int lval, input int psc, input int cmp, input logic cap);
        exp_t e;
        int   nxt;
        bit   step;
        bus.i_enable   = en;
        bus.i_dir      = dir;
        bus.i_sat      = sat;
        bus.i_load     = load;
        bus.i_load_val = CW'(lval);
        bus.i_prescale = PW'(psc);
        bus.i_cmp_val  = CW'(cmp);
`ifdef PRESCALED_COUNTER_CAPTURE_EN
        bus.i_capture  = cap;
`endif
        e.tick    = 0;
        e.tc      = 0;
        e.cap_vld = cap ? 1 : 0;
        if (cap) m_cap = m_count;
        e.cap     = m_cap;
        step      = 1'b0;
        if (load) begin
            m_count = (lval < PMAX) ? lval : PMAX;
            m_psc   = 0;
        end else if (en) begin
            if (m_psc >= psc) begin
                step  = 1'b1;
                m_psc = 0;
            end else begin
                m_psc++;
            end
        end
        if (step) begin
            e.tick = 1;
            if (dir) begin
                if (sat) begin
                    nxt  = (m_count + 1 > PMAX) ? PMAX : m_count + 1;
                    e.tc = (nxt == PMAX && m_count != PMAX) ? 1 : 0;
                end else begin
                    nxt  = (m_count + 1) % (PMAX + 1);
                    e.tc = (nxt < m_count) ? 1 : 0;
                end
            end else begin
                if (sat) begin
                    nxt  = (m_count - 1 < 0) ? 0 : m_count - 1;
                    e.tc = (nxt == 0 && m_count != 0) ? 1 : 0;
                end else begin
                    nxt  = (m_count - 1 + PMAX + 1) % (PMAX + 1);
                    e.tc = (nxt > m_count) ? 1 : 0;
                end
            end
            m_count = nxt;
        end
        e.count = m_count;
        e.match = (m_count == cmp) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected entry per clock edge, sampled 1 ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("count", int'(bus.o_count), e.count);
                check("tick",  int'(bus.o_tick),  e.tick);
                check("tc",    int'(bus.o_tc),    e.tc);
                check("match", int'(bus.o_match), e.match);
`ifdef PRESCALED_COUNTER_CAPTURE_EN
                check("cap_vld", int'(bus.o_capture_vld), e.cap_vld);
                check("cap",     int'(bus.o_capture),     e.cap);
`endif
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_enable   = 1'b0;
        bus.i_dir      = 1'b1;
        bus.i_sat      = 1'b0;
        bus.i_load     = 1'b0;
        bus.i_load_val = '0;
        bus.i_prescale = '0;
        bus.i_cmp_val  = '0;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
        bus.i_capture  = 1'b0;
`endif
        #1;
        check("rst_count", int'(bus.o_count), 0);
        check("rst_tick",  int'(bus.o_tick),  0);
        check("rst_tc",    int'(bus.o_tc),    0);
        check("rst_match", int'(bus.o_match), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Up wrap: 1..9,0,1,2 with tc on the wrap only
        repeat (12) drive(1, 1, 0, 0, 0, 0, 15, 0);

        // Down saturate from 2: 1,0,0,0,0 with one tc
        drive(0, 0, 1, 1, 2, 0, 15, 0);
        repeat (5) drive(1, 0, 1, 0, 0, 0, 15, 0);

        // Prescale 2 with a two-cycle enable gap
        drive(0, 1, 0, 1, 0, 2, 15, 0);
        repeat (4) drive(1, 1, 0, 0, 0, 2, 15, 0);
        repeat (2) drive(0, 1, 0, 0, 0, 2, 15, 0);
        repeat (5) drive(1, 1, 0, 0, 0, 2, 15, 0);

        // Load clamp on a step cycle, then compare match at 9
        drive(0, 1, 0, 1, 3, 0, 15, 0);
        drive(1, 1, 0, 1, 15, 0, 15, 0);
        drive(0, 1, 0, 0, 0, 0, 9, 0);
        drive(0, 1, 0, 0, 0, 0, 9, 0);

        // Asynchronous reset mid-count at 5, between edges
        drive(0, 1, 0, 1, 4, 0, 5, 0);
        drive(1, 1, 0, 0, 0, 0, 5, 0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_count", int'(bus.o_count), 0);
        check("arst_tick",  int'(bus.o_tick),  0);
        check("arst_tc",    int'(bus.o_tc),    0);
        check("arst_match", int'(bus.o_match), 0);
        m_count = 0;
        m_psc   = 0;
        m_cap   = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 15, 0);

`ifdef PRESCALED_COUNTER_CAPTURE_EN
        // Capture while stepping from 4
        drive(0, 1, 0, 1, 4, 0, 15, 0);
        drive(1, 1, 0, 0, 0, 0, 15, 1);
        drive(0, 1, 0, 0, 0, 0, 15, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 8), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 10), ($urandom_range(0, 7) == 0));
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        check("drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
